// File: rtl/mat_seq_pkg.sv
// mat_seq_pkg: shared defaults, plane write-enable one-hots and FSM encoding for mat_seq
package mat_seq_pkg;
  localparam int WORD_LEN_DEF = 16;
  localparam int MATRIX_DIM_DEF = 8;
  localparam int ADDR_BITS_DEF = 7;
  localparam logic [3:0] WE_A_RE = 4'b0001;
  localparam logic [3:0] WE_B_RE = 4'b0010;
  localparam logic [3:0] WE_A_IM = 4'b0100;
  localparam logic [3:0] WE_B_IM = 4'b1000;
  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;
  // load order: A real, A imag, B real, B imag
  function automatic logic [3:0] plane_we(input logic [1:0] p);
    return p == 2'd0 ? WE_A_RE : p == 2'd1 ? WE_A_IM : p == 2'd2 ? WE_B_RE : WE_B_IM;
  endfunction
endpackage

// File: rtl/mat_seq_if.sv
// mat_seq_if: command, load-stream and memory/pair-handshake bundle for mat_seq
interface mat_seq_if import mat_seq_pkg::*; #(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int MATRIX_DIM = MATRIX_DIM_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
);
  localparam int IW = MATRIX_DIM > 1 ? $clog2(MATRIX_DIM) : 1;
  logic start, mode, transpose_b;
  logic s_valid, s_ready;
  logic [WORD_LEN-1:0] s_data, wr_data;
  logic [3:0] we;
  logic [ADDR_BITS-1:0] Dir_M1, Dir_M2;
  logic rd_valid, rd_ready;
  logic [IW-1:0] row_idx, col_idx;
  logic busy, done;
  modport slave (
    input start, mode, transpose_b, s_valid, s_data, rd_ready,
    output s_ready, wr_data, we, Dir_M1, Dir_M2, rd_valid, row_idx, col_idx, busy, done
  );
  modport master (
    output start, mode, transpose_b, s_valid, s_data, rd_ready,
    input s_ready, wr_data, we, Dir_M1, Dir_M2, rd_valid, row_idx, col_idx, busy, done
  );
endinterface

// File: rtl/mat_idx_cnt.sv
// mat_idx_cnt: two-level outer/inner counter with enable, wrap-around and last flag
module mat_idx_cnt #(
  parameter int OUTER = 4,
  parameter int INNER = 4,
  parameter int OW = 2,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [OW-1:0] outer,
  output logic [IW-1:0] inner,
  output logic          last
);
  logic in_wrap;
  assign in_wrap = inner == IW'(INNER - 1);
  assign last = in_wrap && outer == OW'(OUTER - 1);
  always_ff @(posedge clk)
    if (rst) begin
      outer <= '0;
      inner <= '0;
    end else if (en) begin
      inner <= in_wrap ? '0 : inner + 1'b1;
      if (in_wrap) outer <= last ? '0 : outer + 1'b1;
    end
endmodule

// File: rtl/mat_seq.sv
// mat_seq: sequences complex-matrix plane loads and (i,j) address-pair issue for a matrix product
module mat_seq import mat_seq_pkg::*; #(
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int MATRIX_DIM = MATRIX_DIM_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input logic clk,
  input logic rst,
  mat_seq_if.slave bus
);
  localparam int IW = MATRIX_DIM > 1 ? $clog2(MATRIX_DIM) : 1;
  state_t state, nxt;
  logic tr_q, acc, adv, ld_last, cp_last;
  logic [1:0] plane;
  logic [ADDR_BITS-1:0] word;
  logic [IW-1:0] i, j;
  assign acc = state == LOAD && bus.s_valid;
  assign adv = state == COMP && bus.rd_ready;
  mat_idx_cnt #(.OUTER(4), .INNER(MATRIX_DIM * MATRIX_DIM), .OW(2), .IW(ADDR_BITS)) u_ld (
    .clk(clk), .rst(rst), .en(acc), .outer(plane), .inner(word), .last(ld_last)
  );
  mat_idx_cnt #(.OUTER(MATRIX_DIM), .INNER(MATRIX_DIM), .OW(IW), .IW(IW)) u_cp (
    .clk(clk), .rst(rst), .en(adv), .outer(i), .inner(j), .last(cp_last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tr_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) tr_q <= bus.transpose_b;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? (bus.mode ? COMP : LOAD) : IDLE;
      LOAD: nxt = acc && ld_last ? DONE : LOAD;
      COMP: nxt = adv && cp_last ? DONE : COMP;
      default: nxt = IDLE;
    endcase
  end
  // A planes address through Dir_M1, B planes through Dir_M2; the idle port stays at 0
  always_comb begin
    bus.s_ready = state == LOAD;
    bus.we = acc ? plane_we(plane) : 4'b0000;
    bus.wr_data = acc ? bus.s_data : '0;
    bus.Dir_M1 = state == COMP ? ADDR_BITS'(i * MATRIX_DIM) : (acc && !plane[1]) ? word : '0;
    bus.Dir_M2 = state == COMP ? ADDR_BITS'(tr_q ? j * MATRIX_DIM : 32'(j)) : (acc && plane[1]) ? word : '0;
    bus.rd_valid = state == COMP;
    bus.row_idx = state == COMP ? i : '0;
    bus.col_idx = state == COMP ? j : '0;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
endmodule

// File: tb/tb_mat_seq.sv
// tb_mat_seq: directed load/compute/reset/start-ignore checks for mat_seq at N=8
module tb_mat_seq;
  localparam int W = 16;
  localparam int N = 8;
  localparam int A = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  logic [3:0] we_tab [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
  always #5 clk = ~clk;
  mat_seq_if #(.WORD_LEN(W), .MATRIX_DIM(N), .ADDR_BITS(A)) bus ();
  mat_seq #(.WORD_LEN(W), .MATRIX_DIM(N), .ADDR_BITS(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {20'd0, bus.s_ready, bus.we, bus.wr_data, bus.Dir_M1, bus.Dir_M2, bus.rd_valid,
            bus.row_idx, bus.col_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [63:0] ld_obs();
    return {bus.s_ready, bus.we, bus.Dir_M1, bus.Dir_M2, bus.wr_data};
  endfunction

  function automatic logic [63:0] ld_exp(input int k, input logic [W-1:0] d);
    logic [A-1:0] a;
    int p;
    p = k / (N * N);
    a = A'(k % (N * N));
    return {1'b1, we_tab[p], p < 2 ? a : 7'd0, p < 2 ? 7'd0 : a, d};
  endfunction

  function automatic logic [63:0] cp_obs();
    return {bus.rd_valid, bus.Dir_M1, bus.Dir_M2, bus.row_idx, bus.col_idx, bus.we, bus.s_ready};
  endfunction

  function automatic logic [63:0] cp_exp(input int p, input bit tr);
    int i, j;
    i = p / N;
    j = p % N;
    return {1'b1, A'(i * N), tr ? A'(j * N) : A'(j), 3'(i), 3'(j), 4'b0000, 1'b0};
  endfunction

  task automatic go(input logic m, input logic t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.transpose_b = t;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_done(input string tag);
    bus.s_valid = 1'b0;
    #1 check({tag, "_done"}, {bus.busy, bus.done}, 2'b11);
    @(negedge clk);
    #1 check({tag, "_idle"}, {bus.busy, bus.done, bus.s_ready, bus.rd_valid}, 4'b0000);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.transpose_b = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    // continuous load, with a stray start mid-load that must be ignored
    go(1'b0, 1'b0);
    for (int k = 0; k < 4 * N * N; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = W'(k);
      bus.start = k == 10;
      bus.mode = 1'b1;
      #1 check("load", ld_obs(), ld_exp(k, W'(k)));
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.start = 1'b0;
    #1 check("load_done", {bus.busy, bus.done}, 2'b11);
    bus.start = 1'b1;
    bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    #1 check("load_idle", {bus.busy, bus.done, bus.s_ready}, 3'b000);
    @(negedge clk);
    #1 check("start_in_done_ignored", {bus.busy, bus.s_ready}, 2'b00);
    // load with s_valid gaps every other cycle
    go(1'b0, 1'b0);
    for (int c = 0; c < 8 * N * N - 1; c++) begin
      bus.s_valid = c % 2 == 0;
      bus.s_data = W'(c / 2 + 16'h1000);
      #1;
      if (c % 2 == 0) check("gap_load", ld_obs(), ld_exp(c / 2, W'(c / 2 + 16'h1000)));
      else check("gap_we", {bus.we, bus.s_ready, bus.busy}, 6'b000011);
      @(negedge clk);
    end
    finish_done("gap");
    // compute, B not transposed, rd_ready held
    go(1'b1, 1'b0);
    for (int p = 0; p < N * N; p++) begin
      #1 check("comp", cp_obs(), cp_exp(p, 1'b0));
      @(negedge clk);
    end
    finish_done("comp");
    // compute, B transposed, stall at pair (2,5)
    go(1'b1, 1'b1);
    for (int p = 0; p < N * N; p++) begin
      if (p == 2 * N + 5) begin
        bus.rd_ready = 1'b0;
        repeat (3) begin
          #1 check("stall_hold", cp_obs(), {1'b1, 7'd16, 7'd40, 3'd2, 3'd5, 4'b0000, 1'b0});
          @(negedge clk);
        end
        bus.rd_ready = 1'b1;
      end
      #1 check("comp_tr", cp_obs(), cp_exp(p, 1'b1));
      @(negedge clk);
    end
    finish_done("comp_tr");
    // reset at load word 100 aborts with no done pulse
    go(1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data = W'(k);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    #1 check("abort_outs", outs(), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1 check("abort_no_done", {bus.done, bus.busy}, 2'b00);
    end
    go(1'b0, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data = 16'h1234;
    #1 check("restart_load", ld_obs(), ld_exp(0, 16'h1234));
    @(negedge clk);
    bus.s_data = 16'h5678;
    #1 check("restart_load2", ld_obs(), ld_exp(1, 16'h5678));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.s_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
